bp_be_fcsr_accum: RTL and testbench

// - Multi-lane successor to the single fflags/frm encodings: holds the architectural FP control/status

---
 rtl/bp_be_fcsr_accum.sv | 141 ++++++++++++++
 tb/tb_bp_be_fcsr_accum.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fcsr_accum.sv
// FP control/status accumulator: sticky fflags from commit lanes, frm, and CSR access to fflags/frm/fcsr.
// Optional BP_FCSR_ILLEGAL_FRM_EN flags reserved rounding modes on illegal_frm_o.
module bp_be_fcsr_accum #(
    parameter int lanes_p          = 2,
    parameter int csr_data_width_p = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [lanes_p-1:0]          retire_v_i,
    input  logic [5*lanes_p-1:0]        retire_fflags_i,
    input  logic                        csr_v_i,
    output logic                        csr_ready_o,
    input  logic [1:0]                  csr_cmd_i,
    input  logic [11:0]                 csr_addr_i,
    input  logic [csr_data_width_p-1:0] csr_data_i,
    output logic                        csr_v_o,
    output logic [csr_data_width_p-1:0] csr_data_o,
    output logic                        csr_illegal_o,
    input  logic [2:0]                  rm_i,
    output logic [2:0]                  rm_o,
    output logic                        illegal_frm_o,
    output logic [4:0]                  fflags_o,
    output logic [2:0]                  frm_o,
    output logic                        fs_dirty_o
);

    typedef enum logic {e_idle, e_resp} state_e;

    state_e     state_q, state_d;
    logic [4:0] fflags_q, fflags_d, pending_q, pending_d;
    logic [2:0] frm_q, frm_d;
    logic [7:0] rdata_q, rdata_d;
    logic       illegal_q, illegal_d, dirty_q;

    logic [4:0] lane_or, vis;
    logic       accept, addr_ff, addr_frm, addr_fcsr, legal;
    logic [7:0] old_val, opnd, new_val, field_mask;
    logic       unused_data;

    assign unused_data = ^csr_data_i[csr_data_width_p-1:8];

    always_comb begin
        lane_or = '0;
        for (int i = 0; i < lanes_p; i++)
            if (retire_v_i[i]) lane_or = lane_or | retire_fflags_i[5*i +: 5];
    end

    // CSR reads see flags still in flight, including this cycle's retirements
    assign vis       = fflags_q | pending_q | lane_or;
    assign accept    = csr_v_i & (state_q == e_idle);
    assign addr_ff   = (csr_addr_i == 12'h001);
    assign addr_frm  = (csr_addr_i == 12'h002);
    assign addr_fcsr = (csr_addr_i == 12'h003);
    assign legal     = addr_ff | addr_frm | addr_fcsr;

    always_comb begin
        old_val    = '0;
        field_mask = '0;
        if (addr_ff) begin
            old_val    = {3'b000, vis};
            field_mask = 8'h1F;
        end else if (addr_frm) begin
            old_val    = {5'b00000, frm_q};
            field_mask = 8'h07;
        end else if (addr_fcsr) begin
            old_val    = {frm_q, vis};
            field_mask = 8'hFF;
        end
        opnd = csr_data_i[7:0] & field_mask;
        unique case (csr_cmd_i)
            2'b00:   new_val = old_val;
            2'b01:   new_val = opnd;
            2'b10:   new_val = old_val | opnd;
            default: new_val = old_val & ~opnd;
        endcase
    end

    always_comb begin
        fflags_d  = fflags_q | pending_q;
        pending_d = lane_or;
        frm_d     = frm_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        state_d   = (state_q == e_resp) ? e_idle : state_q;
        if (accept) begin
            state_d   = e_resp;
            rdata_d   = legal ? old_val : 8'h00;
            illegal_d = ~legal;
            if (legal && csr_cmd_i != 2'b00) begin
                // pending and lane flags are already folded into new_val / vis
                pending_d = '0;
                if (addr_ff) begin
                    fflags_d = new_val[4:0];
                end else if (addr_frm) begin
                    frm_d    = new_val[2:0];
                    fflags_d = vis;
                end else begin
                    fflags_d = new_val[4:0];
                    frm_d    = new_val[7:5];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= e_idle;
            fflags_q  <= '0;
            pending_q <= '0;
            frm_q     <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fflags_q  <= fflags_d;
            pending_q <= pending_d;
            frm_q     <= frm_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
            dirty_q   <= (fflags_d != fflags_q) || (frm_d != frm_q);
        end
    end

    assign csr_ready_o   = (state_q == e_idle);
    assign csr_v_o       = (state_q == e_resp);
    assign csr_data_o    = {{(csr_data_width_p-8){1'b0}}, rdata_q};
    assign csr_illegal_o = illegal_q;
    assign fflags_o      = fflags_q;
    assign frm_o         = frm_q;
    assign fs_dirty_o    = dirty_q;
    assign rm_o          = (rm_i == 3'b111) ? frm_q : rm_i;

`ifdef BP_FCSR_ILLEGAL_FRM_EN
    assign illegal_frm_o = (rm_i == 3'b101) || (rm_i == 3'b110) ||
                           ((rm_i == 3'b111) && (frm_q >= 3'b101));
`else
    assign illegal_frm_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_be_fcsr_accum.sv
// Self-checking bench for bp_be_fcsr_accum: directed scenarios plus randomized run against a reference model.
module tb_bp_be_fcsr_accum;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  retire_v;
    logic [9:0]  retire_fflags;
    logic        csr_v, csr_ready;
    logic [1:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [63:0] csr_data, csr_rdata;
    logic        csr_v_o, csr_illegal;
    logic [2:0]  rm_i, rm_o, frm_o;
    logic        illegal_frm;
    logic [4:0]  fflags_o;
    logic        fs_dirty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bp_be_fcsr_accum #(.lanes_p(2), .csr_data_width_p(64)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .retire_v_i(retire_v), .retire_fflags_i(retire_fflags),
        .csr_v_i(csr_v), .csr_ready_o(csr_ready), .csr_cmd_i(csr_cmd),
        .csr_addr_i(csr_addr), .csr_data_i(csr_data),
        .csr_v_o(csr_v_o), .csr_data_o(csr_rdata), .csr_illegal_o(csr_illegal),
        .rm_i(rm_i), .rm_o(rm_o), .illegal_frm_o(illegal_frm),
        .fflags_o(fflags_o), .frm_o(frm_o), .fs_dirty_o(fs_dirty)
    );

    task automatic idle_inputs();
        retire_v = '0; retire_fflags = '0;
        csr_v = 1'b0; csr_cmd = '0; csr_addr = '0; csr_data = '0;
        rm_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic csr_req(input logic [1:0] cmd, input logic [11:0] addr, input logic [63:0] d);
        csr_v = 1'b1; csr_cmd = cmd; csr_addr = addr; csr_data = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (csr_ready !== 1'b1 || csr_v_o !== 1'b0 || csr_rdata !== 64'd0 || csr_illegal !== 1'b0 ||
            fs_dirty !== 1'b0 || fflags_o !== 5'd0 || frm_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: ready=%b v=%b data=%h ill=%b dirty=%b fflags=%b frm=%b, required 1 0 0 0 0 0 0",
                     csr_ready, csr_v_o, csr_rdata, csr_illegal, fs_dirty, fflags_o, frm_o);
        end
        do_reset();
    endtask

    task automatic test_lane_merge();
        do_reset();
        retire_v = 2'b11; retire_fflags = {5'b10000, 5'b00001};
        tick();
        idle_inputs();
        n_checks++;
        if (fflags_o !== 5'b00000) begin
            n_fail++; $display("FAIL lane_latency1: fflags=%b required 00000", fflags_o);
        end
        tick();
        n_checks++;
        if (fflags_o !== 5'b10001 || fs_dirty !== 1'b1) begin
            n_fail++; $display("FAIL lane_merge: fflags=%b dirty=%b required 10001 1", fflags_o, fs_dirty);
        end
        tick();
        n_checks++;
        if (fs_dirty !== 1'b0 || fflags_o !== 5'b10001) begin
            n_fail++; $display("FAIL lane_dirty_pulse: dirty=%b fflags=%b required 0 10001", fs_dirty, fflags_o);
        end
        // flags with v=0 must be ignored
        retire_v = 2'b00; retire_fflags = {5'b01000, 5'b00100};
        tick(); idle_inputs(); tick();
        n_checks++;
        if (fflags_o !== 5'b10001 || fs_dirty !== 1'b0) begin
            n_fail++; $display("FAIL lane_invalid: fflags=%b dirty=%b required 10001 0", fflags_o, fs_dirty);
        end
    endtask

    task automatic test_read_fwd();
        do_reset();
        retire_v = 2'b01; retire_fflags = {5'b00000, 5'b00100};
        csr_req(2'b00, 12'h001, 64'hFFFF);
        n_checks++;
        if (csr_ready !== 1'b1) begin
            n_fail++; $display("FAIL read_ready: ready=%b required 1", csr_ready);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (csr_v_o !== 1'b1 || csr_rdata !== 64'h4 || csr_illegal !== 1'b0 || fs_dirty !== 1'b0 || csr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_fwd: v=%b data=%h ill=%b dirty=%b ready=%b required 1 4 0 0 0",
                     csr_v_o, csr_rdata, csr_illegal, fs_dirty, csr_ready);
        end
        tick();
        n_checks++;
        if (csr_v_o !== 1'b0 || fflags_o !== 5'b00100 || csr_ready !== 1'b1) begin
            n_fail++; $display("FAIL read_after: v=%b fflags=%b ready=%b required 0 00100 1", csr_v_o, fflags_o, csr_ready);
        end
    endtask

    task automatic test_clear_fcsr();
        do_reset();
        retire_v = 2'b01; retire_fflags = {5'b00000, 5'b11111};
        tick(); idle_inputs(); tick(); tick();
        retire_v = 2'b10; retire_fflags = {5'b00010, 5'b00000};
        csr_req(2'b11, 12'h003, 64'hFF);
        tick();
        idle_inputs();
        n_checks++;
        if (csr_v_o !== 1'b1 || csr_rdata !== 64'h1F || fflags_o !== 5'd0 || frm_o !== 3'd0) begin
            n_fail++; $display("FAIL clear_fcsr: v=%b data=%h fflags=%b frm=%b required 1 1f 00000 000",
                               csr_v_o, csr_rdata, fflags_o, frm_o);
        end
        tick(); tick();
        n_checks++;
        if (fflags_o !== 5'd0) begin
            n_fail++; $display("FAIL clear_stays: fflags=%b required 00000", fflags_o);
        end
    endtask

    task automatic test_frm_rm();
        logic exp_ill;
        do_reset();
        csr_req(2'b01, 12'h002, 64'h2);
        tick(); idle_inputs();
        n_checks++;
        if (frm_o !== 3'b010 || csr_rdata !== 64'h0 || fs_dirty !== 1'b1) begin
            n_fail++; $display("FAIL frm_write: frm=%b data=%h dirty=%b required 010 0 1", frm_o, csr_rdata, fs_dirty);
        end
        tick();
        rm_i = 3'b111; #1;
        n_checks++;
        if (rm_o !== 3'b010 || illegal_frm !== 1'b0) begin
            n_fail++; $display("FAIL rm_dyn: rm_o=%b ill=%b required 010 0", rm_o, illegal_frm);
        end
        rm_i = 3'b011; #1;
        n_checks++;
        if (rm_o !== 3'b011) begin
            n_fail++; $display("FAIL rm_static: rm_o=%b required 011", rm_o);
        end
        // same-value write must not pulse dirty
        csr_req(2'b01, 12'h002, 64'h2);
        tick(); idle_inputs();
        n_checks++;
        if (fs_dirty !== 1'b0 || frm_o !== 3'b010) begin
            n_fail++; $display("FAIL frm_same: dirty=%b frm=%b required 0 010", fs_dirty, frm_o);
        end
        tick();
        csr_req(2'b01, 12'h002, 64'h5);
        tick(); idle_inputs(); tick();
`ifdef BP_FCSR_ILLEGAL_FRM_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        rm_i = 3'b111; #1;
        n_checks++;
        if (rm_o !== 3'b101 || illegal_frm !== exp_ill) begin
            n_fail++; $display("FAIL rm_frm5: rm_o=%b ill=%b required 101 %b", rm_o, illegal_frm, exp_ill);
        end
        rm_i = 3'b110; #1;
        n_checks++;
        if (rm_o !== 3'b110 || illegal_frm !== exp_ill) begin
            n_fail++; $display("FAIL rm_raw6: rm_o=%b ill=%b required 110 %b", rm_o, illegal_frm, exp_ill);
        end
        rm_i = 3'b100; #1;
        n_checks++;
        if (rm_o !== 3'b100 || illegal_frm !== 1'b0) begin
            n_fail++; $display("FAIL rm_raw4: rm_o=%b ill=%b required 100 0", rm_o, illegal_frm);
        end
        rm_i = 3'b000;
    endtask

    task automatic test_illegal();
        do_reset();
        csr_req(2'b01, 12'h003, 64'h63);  // frm=3, fflags=00011
        tick(); idle_inputs(); tick(); tick();
        csr_req(2'b01, 12'h300, 64'hFF);
        tick(); idle_inputs();
        n_checks++;
        if (csr_v_o !== 1'b1 || csr_illegal !== 1'b1 || csr_rdata !== 64'h0 || csr_ready !== 1'b0 ||
            frm_o !== 3'b011 || fflags_o !== 5'b00011 || fs_dirty !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_addr: v=%b ill=%b data=%h ready=%b frm=%b fflags=%b dirty=%b required 1 1 0 0 011 00011 0",
                     csr_v_o, csr_illegal, csr_rdata, csr_ready, frm_o, fflags_o, fs_dirty);
        end
        tick();
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        csr_req(2'b01, 12'h003, 64'hFF);
        tick(); idle_inputs();
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (csr_v_o !== 1'b0 || fflags_o !== 5'd0 || frm_o !== 3'd0 || csr_rdata !== 64'd0 ||
            csr_ready !== 1'b1 || fs_dirty !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_resp: v=%b fflags=%b frm=%b data=%h ready=%b dirty=%b required 0 0 0 0 1 0",
                               csr_v_o, fflags_o, frm_o, csr_rdata, csr_ready, fs_dirty);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (csr_ready !== 1'b1 || csr_v_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b v=%b required 1 0", csr_ready, csr_v_o);
        end
    endtask

    // Reference: fcsr is an 8-bit value {frm,fflags}; lane flags reach it two cycles after retiring.
    task automatic test_random();
        int m_ff, m_pend, m_frm, m_data, m_busy, m_ill, m_dirty;
        int lane, vis, old, d, nv, nff, nfrm, cmd, sel, addr;
        bit acc;
        do_reset();
        m_ff = 0; m_pend = 0; m_frm = 0; m_data = 0; m_busy = 0; m_ill = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            retire_v      = 2'($urandom_range(0, 3));
            retire_fflags = 10'($urandom);
            if ($urandom_range(0, 5) == 0) retire_v = 2'b00;
            csr_v = 1'($urandom_range(0, 1));
            cmd   = int'($urandom_range(0, 3));
            sel   = int'($urandom_range(0, 4));
            addr  = (sel < 3) ? sel + 1 : ((sel == 3) ? 12'h300 : int'($urandom_range(4, 4095)));
            csr_cmd = 2'(cmd); csr_addr = 12'(addr); csr_data = {$urandom, $urandom};
            lane = 0;
            if (retire_v[0]) lane = lane | int'(retire_fflags[4:0]);
            if (retire_v[1]) lane = lane | int'(retire_fflags[9:5]);
            vis  = m_ff | m_pend | lane;
            acc  = csr_v && (m_busy == 0);
            nff  = m_ff | m_pend;
            nfrm = m_frm;
            m_pend = lane;
            if (acc) begin
                if (addr >= 1 && addr <= 3) begin
                    old = (addr == 1) ? vis : (addr == 2) ? m_frm : m_frm * 32 + vis;
                    d   = int'(csr_data[7:0]) % ((addr == 1) ? 32 : (addr == 2) ? 8 : 256);
                    nv  = (cmd == 1) ? d : (cmd == 2) ? (old | d) : (cmd == 3) ? (old & ~d) : old;
                    m_data = old; m_ill = 0;
                    if (cmd != 0) begin
                        m_pend = 0;
                        if (addr == 1) nff = nv % 32;
                        else if (addr == 2) begin nfrm = nv % 8; nff = vis; end
                        else begin nff = nv % 32; nfrm = nv / 32; end
                    end
                end else begin
                    m_data = 0; m_ill = 1;
                end
            end
            m_dirty = (nff != m_ff || nfrm != m_frm) ? 1 : 0;
            m_ff = nff; m_frm = nfrm; m_busy = acc ? 1 : 0;
            tick();
            n_checks++;
            if (fflags_o !== 5'(m_ff) || frm_o !== 3'(m_frm) || fs_dirty !== 1'(m_dirty) ||
                csr_v_o !== 1'(m_busy) || csr_ready !== 1'(m_busy == 0)) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d: fflags=%b frm=%b dirty=%b v=%b ready=%b required %b %b %b %b %b",
                         cyc, fflags_o, frm_o, fs_dirty, csr_v_o, csr_ready,
                         5'(m_ff), 3'(m_frm), 1'(m_dirty), 1'(m_busy), 1'(m_busy == 0));
            end
            if (m_busy == 1) begin
                n_checks++;
                if (csr_rdata !== 64'(m_data) || csr_illegal !== 1'(m_ill)) begin
                    n_fail++;
                    $display("FAIL rand_resp cyc=%0d: data=%h ill=%b required %h %b",
                             cyc, csr_rdata, csr_illegal, 64'(m_data), 1'(m_ill));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_lane_merge();
        test_read_fwd();
        test_clear_fcsr();
        test_frm_rm();
        test_illegal();
        test_reset_mid_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
